// File: rtl/disp_pkg.sv
// Shared constants for the multiplexed four-digit seven-segment driver:
// segment decode table, blank pattern and anode select patterns.
package disp_pkg;

    localparam int unsigned NUM_DIGITS = 4;

    typedef logic [1:0] digit_sel_t;

    // Active-low gfedcba patterns, indexed by hex value
    localparam logic [6:0] SEG_TABLE [16] = '{
        7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
        7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
        7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
        7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
    };

    localparam logic [6:0] SEG_BLANK = 7'b1111111;

    // Active-low one-hot anode select, indexed by digit number
    localparam logic [3:0] ANODE_TABLE [NUM_DIGITS] = '{
        4'b1110, 4'b1101, 4'b1011, 4'b0111
    };

endpackage

// File: rtl/hex_to_sseg.sv
// Hex digit to active-low seven-segment (gfedcba) decoder.
module hex_to_sseg
    import disp_pkg::*;
(
    input  logic [3:0] hex_i,
    output logic [6:0] seg_o
);

    assign seg_o = SEG_TABLE[hex_i];

endmodule

// File: rtl/disp_hex_mux.sv
// Time-multiplexed four-digit hex display driver with decimal points.
// Optional leading-zero blanking is enabled by defining DISP_HEX_MUX_LZB_EN.
module disp_hex_mux
    import disp_pkg::*;
#(
    parameter int N = 18
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] hex3,
    input  logic [3:0] hex2,
    input  logic [3:0] hex1,
    input  logic [3:0] hex0,
    input  logic [3:0] dp_in,
    output logic [3:0] an,
    output logic [7:0] sseg
);

    logic [N-1:0] q_q;
    logic [N-1:0] q_d;
    digit_sel_t   sel;
    logic [3:0]   hex_sel;
    logic         dp_sel;
    logic [6:0]   seg_dec;
    logic         blank;

    always_comb begin
        q_d = q_q + {{(N-1){1'b0}}, 1'b1};
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            q_q <= '0;
        end else begin
            q_q <= q_d;
        end
    end

    // Top two bits of the refresh counter pick the digit, so each digit
    // stays lit for 2^(N-2) cycles.
    assign sel = q_q[N-1:N-2];

    always_comb begin
        hex_sel = hex0;
        unique case (sel)
            2'd0: hex_sel = hex0;
            2'd1: hex_sel = hex1;
            2'd2: hex_sel = hex2;
            2'd3: hex_sel = hex3;
        endcase
    end

    assign dp_sel = dp_in[sel];
    assign an     = ANODE_TABLE[sel];

    hex_to_sseg u_hex_to_sseg (
        .hex_i (hex_sel),
        .seg_o (seg_dec)
    );

`ifdef DISP_HEX_MUX_LZB_EN
    // A digit is blanked only when it and every digit to its left are zero.
    always_comb begin
        blank = 1'b0;
        unique case (sel)
            2'd0: blank = 1'b0;
            2'd1: blank = (hex3 == 4'h0) && (hex2 == 4'h0) && (hex1 == 4'h0);
            2'd2: blank = (hex3 == 4'h0) && (hex2 == 4'h0);
            2'd3: blank = (hex3 == 4'h0);
        endcase
    end
`else
    assign blank = 1'b0;
`endif

    assign sseg = {~dp_sel, (blank ? SEG_BLANK : seg_dec)};

endmodule

// File: tb/tb_disp_hex_mux.sv
// Directed bench for disp_hex_mux: one N=4 instance for scan behaviour and
// one default-width instance for reset and decode behaviour.
module tb_disp_hex_mux;

    logic       clk;
    logic       reset;
    logic [3:0] hex3, hex2, hex1, hex0;
    logic [3:0] dp_in;
    logic [3:0] an_s, an_d;
    logic [7:0] sseg_s, sseg_d;

    int n_chk  = 0;
    int n_pass = 0;

    disp_hex_mux #(.N(4)) dut4 (
        .clk   (clk),
        .reset (reset),
        .hex3  (hex3),
        .hex2  (hex2),
        .hex1  (hex1),
        .hex0  (hex0),
        .dp_in (dp_in),
        .an    (an_s),
        .sseg  (sseg_s)
    );

    disp_hex_mux dut18 (
        .clk   (clk),
        .reset (reset),
        .hex3  (hex3),
        .hex2  (hex2),
        .hex1  (hex1),
        .hex0  (hex0),
        .dp_in (dp_in),
        .an    (an_d),
        .sseg  (sseg_d)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    logic [6:0] exp_seg [16] = '{
        7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
        7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
        7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
        7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
    };
    logic [3:0] scan_an   [4] = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
    logic [7:0] scan_sseg [4] = '{8'b00001000, 8'b00000011, 8'b01000110, 8'b00100001};
    logic [7:0] lz_sseg   [4];

    initial begin
        // Reset with all zero inputs, held 100 ns
        reset = 1'b1;
        hex3 = 4'h0; hex2 = 4'h0; hex1 = 4'h0; hex0 = 4'h0;
        dp_in = 4'b0000;
        #100;
        check("rst_an_N18",   {4'b0, an_d}, 8'b00001110);
        check("rst_sseg_N18", sseg_d, 8'b11000000);
        check("rst_an_N4",    {4'b0, an_s}, 8'b00001110);
        check("rst_q_N4",     {4'b0, dut4.q_q}, 8'b00000000);

        // Zero-latency decode on digit 0
        hex0 = 4'h7; dp_in = 4'b0000; #1;
        check("hex7_dp0", sseg_d, 8'b11111000);
        hex0 = 4'h5; dp_in = 4'b0001; #1;
        check("hex5_dp1", sseg_d, 8'b00010010);
        dp_in = 4'b1110; #1;
        check("dp_other_digits", sseg_d, 8'b10010010);

        dp_in = 4'b0000;
        for (int i = 0; i < 16; i++) begin
            hex0 = 4'(i); #1;
            check($sformatf("sweep_%0h", i), sseg_d, {1'b1, exp_seg[i]});
        end

        // Full scan at N=4
        hex3 = 4'hD; hex2 = 4'hC; hex1 = 4'hB; hex0 = 4'hA;
        dp_in = 4'b1111;
        tick();
        reset = 1'b0;
        #1;
        for (int c = 0; c <= 16; c++) begin
            check($sformatf("scan_an_c%0d", c),   {4'b0, an_s}, {4'b0, scan_an[(c / 4) % 4]});
            check($sformatf("scan_sseg_c%0d", c), sseg_s, scan_sseg[(c / 4) % 4]);
            tick();
        end
        // q is now 1: digit 0 still active; changing input shows at once
        hex0 = 4'h3; dp_in = 4'b0000; #1;
        check("live_sseg", sseg_s, 8'b10110000);
        check("live_an",   {4'b0, an_s}, 8'b00001110);
        check("live_N18",  sseg_d, 8'b10110000);
        tick(); tick(); tick();
        check("no_restart_an", {4'b0, an_s}, 8'b00001101);
        check("no_restart_q",  {4'b0, dut4.q_q}, 8'd4);

        // Reset in the middle of digit 2
        tick(); tick(); tick(); tick();
        check("pre_rst_an", {4'b0, an_s}, 8'b00001011);
        reset = 1'b1;
        tick();
        check("mid_rst_an", {4'b0, an_s}, 8'b00001110);
        check("mid_rst_q",  {4'b0, dut4.q_q}, 8'd0);
        check("mid_rst_sseg", sseg_s, 8'b10110000);
        reset = 1'b0;
        tick();
        check("post_rst_q", {4'b0, dut4.q_q}, 8'd1);

        // Leading-zero handling with 0,0,0,3
        hex3 = 4'h0; hex2 = 4'h0; hex1 = 4'h0; hex0 = 4'h3;
        dp_in = 4'b0000;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        #1;
`ifdef DISP_HEX_MUX_LZB_EN
        lz_sseg = '{8'b10110000, 8'b11111111, 8'b11111111, 8'b11111111};
`else
        lz_sseg = '{8'b10110000, 8'b11000000, 8'b11000000, 8'b11000000};
`endif
        for (int d = 0; d < 4; d++) begin
            check($sformatf("lz_an_d%0d", d),   {4'b0, an_s}, {4'b0, scan_an[d]});
            check($sformatf("lz_sseg_d%0d", d), sseg_s, lz_sseg[d]);
            if (d == 3) begin
                dp_in = 4'b1000; #1;
                check("lz_dp_d3", sseg_s, {1'b0, lz_sseg[3][6:0]});
                dp_in = 4'b0000;
            end
            tick(); tick(); tick(); tick();
        end
        // Digit 1 nonzero: only digits 3 and 2 may blank
        hex1 = 4'h1; tick(); tick(); tick(); tick(); #0;
`ifdef DISP_HEX_MUX_LZB_EN
        check("lz_d1_shown", sseg_s, 8'b11111001);
`else
        check("lz_d1_shown", sseg_s, 8'b11111001);
`endif
        check("lz_d1_an", {4'b0, an_s}, 8'b00001101);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/disp_hex_mux.md
DISP_HEX_MUX -- requirements
Module: disp_hex_mux

Interface
REQ-001 The block SHALL have parameter N, default 18, meaning refresh-counter width; legal range 4..32.
REQ-002 The block SHALL have one clock and a synchronous, active-high reset.
REQ-003 Port clk, input, 1 bit: rising-edge clock.
REQ-004 Port reset, input, 1 bit: synchronous, active-high reset.
REQ-005 Port hex3, input, 4 bits: hex value for digit 3 (leftmost).
REQ-006 Port hex2, input, 4 bits: hex value for digit 2.
REQ-007 Port hex1, input, 4 bits: hex value for digit 1.
REQ-008 Port hex0, input, 4 bits: hex value for digit 0 (rightmost).
REQ-009 Port dp_in, input, 4 bits: decimal-point enables; bit k belongs to digit k; 1 = point lit.
REQ-010 Port an, output, 4 bits: active-low one-hot anode select.
REQ-011 Port sseg, output, 8 bits: active-low segments; bit 7 = dp, bits 6..0 = g,f,e,d,c,b,a.

Function
REQ-012 The block SHALL hold an N-bit free-running counter q that increments by 1 every clk and wraps from 2^N-1 to 0.
REQ-013 The digit select SHALL be sel = q[N-1:N-2], so each digit is active for 2^(N-2) consecutive cycles in the order 0,1,2,3,0,...
REQ-014 an SHALL be 1110 for sel=0, 1101 for sel=1, 1011 for sel=2 and 0111 for sel=3.
REQ-015 sseg SHALL be combinational from sel and the current inputs, with zero-cycle latency from hexk/dp_in to sseg.
REQ-016 sseg[6:0] SHALL decode the selected hex value as active-low gfedcba:
- 0=1000000, 1=1111001, 2=0100100, 3=0110000
- 4=0011001, 5=0010010, 6=0000010, 7=1111000
- 8=0000000, 9=0010000, A=0001000, b=0000011
- C=1000110, d=0100001, E=0000110, F=0001110
REQ-017 sseg[7] SHALL equal ~dp_in[sel].
REQ-018 Input changes while a digit is active SHALL appear on sseg immediately; the scan SHALL NOT restart.

Reset
REQ-019 On reset=1 at a rising clk edge, q SHALL be cleared to 0; during and right after reset, an=1110 and sseg shows digit 0 per hex0/dp_in[0].
REQ-020 Reset asserted mid-scan SHALL return the scan to digit 0 on the next edge; reset SHALL take priority over counting.

Configuration
REQ-021 When macro DISP_HEX_MUX_LZB_EN is defined, leading-zero blanking SHALL be applied:
- digit 3 blanked if hex3=0; digit 2 blanked if hex3=hex2=0; digit 1 blanked if hex3=hex2=hex1=0.
- A blanked digit drives sseg[6:0]=1111111; its dp bit still follows dp_in; an is unaffected.
- Digit 0 is never blanked.
REQ-022 Without DISP_HEX_MUX_LZB_EN, no blanking SHALL occur and the behaviour is exactly REQ-016.

Structure
REQ-023 A shared package disp_pkg SHALL hold the 16-entry segment-pattern constant, the blank pattern 7'b1111111 and the anode-pattern constants.
REQ-024 The hex-to-segment decode SHALL be a sub-module hex_to_sseg (4-bit hex in, 7-bit active-low segments out), instantiated once after the digit mux.

Verification
REQ-025 Benches SHALL use N=4 for scan tests (4 cycles per digit) and the default N for reset/decode tests.
REQ-026 Scenario: reset, all hex=0, dp_in=0, hold 100 ns at N=18 -> an=1110, sseg=8'b11000000.
REQ-027 Scenario: hex0=7, dp_in=0 -> sseg=8'b11111000; then hex0=5, dp_in=0001 -> sseg=8'b00010010.
REQ-028 Scenario (N=4): hex3..0=D,C,B,A, dp_in=1111, run 16 cycles after reset ->
- cycles 0-3: an=1110, sseg=00001000
- cycles 4-7: an=1101, sseg=00000011
- cycles 8-11: an=1011, sseg=01000110
- cycles 12-15: an=0111, sseg=00100001
- cycle 16: wraps to digit 0.
REQ-029 Scenario: sweep hex0 over 0..F with sel=0 -> sseg[6:0] matches every REQ-016 entry.
REQ-030 Scenario (N=4): assert reset for one cycle while sel=2 -> next cycle an=1110 and q=0.
REQ-031 Scenario (N=4, DISP_HEX_MUX_LZB_EN defined): hex3..0=0,0,0,3 -> digits 3..1 show 1111111 and digit 0 shows 0110000.
